emif_tx_responder: RTL and testbench
====================================

Name: emif_tx_responder

Overview:
- FPGA-side responder for asynchronous EMIF read cycles from the DSP.
- Detects a read strobe (CS_n and OE_n both low) and fetches the addressed word from the internal register file. It then drives the data onto the EMIF bus until the strobe ends.
- It is the transmit counterpart of the EMIF receive registers. It gives coherent 32-bit reads over a 16-bit bus using a high-half shadow register.

Parameters:
ADDR_WIDTH, 8, EMIF half-word address width; bit 0 selects the low or high half of a 32-bit word.
DATA_WIDTH, 16, EMIF data bus width.
SYNC_STEPS, 2, synchroniser depth for CS_n/OE_n; values below 2 are treated as 2.
RD_LATENCY, 1, cycles from rd_req_o to valid rd_data_i; range 1..3.

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
emif_cs_n_i  in  1  EMIF chip select, active low, asynchronous
emif_oe_n_i  in  1  EMIF output enable, active low, asynchronous
emif_addr_i  in  ADDR_WIDTH  EMIF half-word address, stable for the whole strobe
emif_data_o  out  DATA_WIDTH  registered read data toward the bus pads
emif_data_oe_o  out  1  registered pad output enable; the top level builds the tristate
rd_addr_o  out  ADDR_WIDTH-1  32-bit word address to the register file
rd_req_o  out  1  one-cycle read request pulse
rd_data_i  in  2*DATA_WIDTH  register-file word, valid RD_LATENCY cycles after rd_req_o
late_o  out  1  one-cycle pulse when a strobe ends before data was driven

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: emif_data_o=0, emif_data_oe_o=0, rd_req_o=0, late_o=0, rd_addr_o=0, state=IDLE, shadow_valid=0.
- Synchronisation: CS_n and OE_n each pass through a SYNC_STEPS flip-flop chain. active = ~cs_s & ~oe_s. active_d is the registered active.
  - active_d resets to 1, so a strobe already in progress at reset release is ignored.
  - Start event = active & ~active_d (rising edge of active).
- Address capture: on the start event, addr_r <= emif_addr_i. The address is not synchronised; the bus guarantees it is stable before the strobe.
- State machine IDLE -> FETCH -> DRIVE -> IDLE:
  - IDLE: on the start event, capture addr_r.
    - If addr_r[0]=1, shadow_valid=1 and shadow_addr == addr_r[ADDR_WIDTH-1:1]: load emif_data_o <= shadow and go to DRIVE. No fetch is made; emif_data_oe_o=1 from the next cycle.
    - Otherwise: pulse rd_req_o for 1 cycle, set rd_addr_o = addr_r[ADDR_WIDTH-1:1], load cnt = RD_LATENCY, and go to FETCH.
  - FETCH: decrement cnt; when it reaches 0, rd_data_i is valid.
    - addr_r[0]=0: emif_data_o <= rd_data_i[DATA_WIDTH-1:0]; shadow <= rd_data_i[2*DATA_WIDTH-1:DATA_WIDTH]; shadow_addr <= word address; shadow_valid <= 1.
    - addr_r[0]=1 (shadow miss): emif_data_o <= upper half; shadow unchanged.
    - Then emif_data_oe_o <= 1 and go to DRIVE.
    - If active drops during FETCH: abort to IDLE, pulse late_o, keep emif_data_oe_o=0, and leave the shadow unchanged.
  - DRIVE: hold emif_data_o and emif_data_oe_o=1 while active=1. When active=0, emif_data_oe_o <= 0 on that edge and go to IDLE.
- Shadow rules:
  - Any low-half read overwrites the shadow.
  - A high-half read with a matching shadow invalidates it (shadow_valid <= 0) when entering DRIVE, so one low read serves exactly one coherent high read.
- Re-arming: a new read is accepted only after a fresh rising edge of active. Back-to-back strobes need at least one synchronised cycle with active=0.
- Latency: data is driven SYNC_STEPS+RD_LATENCY+2 cycles after CS_n/OE_n go low (shadow hit: SYNC_STEPS+1). The bus strobe width is set in the DSP to cover this.
- Reset mid-operation: emif_data_oe_o drops on the reset edge, the shadow is invalidated, and the in-flight strobe is ignored until its end.

Decomposition:
- Shared package: EMIF constants (default widths, state encoding IDLE/FETCH/DRIVE) and a function computing the sync depth, max(2, SYNC_STEPS).
- One natural sub-module: emif_strobe_sync, the parameterised synchroniser chain plus rising-edge detect that produces active and start.

Test Plan:
- Low-half read, addr 0x10, rd_data_i=0xBEEF_1234, RD_LATENCY=1 -> one rd_req_o with rd_addr_o=0x08. emif_data_o=0x1234 and oe=1 appear 5 cycles after CS/OE fall (SYNC_STEPS+RD_LATENCY+2). oe drops within 3 cycles of OE_n rising.
- Then high-half read, addr 0x11, with rd_data_i changed to 0x0000_0000 -> no rd_req_o; emif_data_o=0xBEEF (coherent). A repeated 0x11 read then fetches fresh data: rd_req_o and emif_data_o=0x0000.
- High-half read, addr 0x21, with no matching shadow, rd_data_i=0xCAFE_0001 -> rd_req_o with rd_addr_o=0x10; emif_data_o=0xCAFE.
- Strobe only 3 cycles wide, RD_LATENCY=3 -> late_o pulses once, emif_data_oe_o never asserts, and the shadow is unchanged.
- Assert reset_i for 1 cycle while in DRIVE with OE_n held low -> oe=0 next cycle and no new rd_req_o until OE_n rises and falls again; the next 0x11 read misses the shadow.
- CS_n low but OE_n high (write cycle) for 10 cycles -> no rd_req_o and oe stays 0.

Source files
------------

// File: rtl/emif_tx_responder_pkg.sv
// Shared constants, state encoding and helpers for the EMIF read responder.
package emif_tx_responder_pkg;

  localparam int EMIF_ADDR_WIDTH = 8;
  localparam int EMIF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRIVE = 2'd2
  } emif_state_e;

  function automatic int sync_depth(input int steps);
    return (steps < 2) ? 2 : steps;
  endfunction

  function automatic int clamp_latency(input int lat);
    if (lat < 1) return 1;
    if (lat > 3) return 3;
    return lat;
  endfunction

endpackage

// File: rtl/emif_strobe_sync.sv
// Synchronises the asynchronous CS_n/OE_n strobes and flags the rising edge of
// the combined read-active condition.
module emif_strobe_sync
  import emif_tx_responder_pkg::*;
#(
  parameter int SYNC_STEPS = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic cs_n_i,
  input  logic oe_n_i,
  output logic active_o,
  output logic start_o
);

  localparam int DEPTH = sync_depth(SYNC_STEPS);

  logic [DEPTH-1:0] cs_sync;
  logic [DEPTH-1:0] oe_sync;
  logic             active_d;

  // Chains are left unreset so a strobe held across reset still reads as
  // active afterwards and is not mistaken for a new one.
  always_ff @(posedge clk_i) begin
    cs_sync <= {cs_sync[DEPTH-2:0], cs_n_i};
    oe_sync <= {oe_sync[DEPTH-2:0], oe_n_i};
  end

  assign active_o = ~cs_sync[DEPTH-1] & ~oe_sync[DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) active_d <= 1'b1;
    else         active_d <= active_o;
  end

  assign start_o = active_o & ~active_d;

endmodule

// File: rtl/emif_tx_responder.sv
// Answers asynchronous EMIF read strobes from the register file, giving
// coherent 32-bit reads over the 16-bit bus through a high-half shadow.
module emif_tx_responder
  import emif_tx_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = EMIF_ADDR_WIDTH,
  parameter int DATA_WIDTH = EMIF_DATA_WIDTH,
  parameter int SYNC_STEPS = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    emif_cs_n_i,
  input  logic                    emif_oe_n_i,
  input  logic [ADDR_WIDTH-1:0]   emif_addr_i,
  output logic [DATA_WIDTH-1:0]   emif_data_o,
  output logic                    emif_data_oe_o,
  output logic [ADDR_WIDTH-2:0]   rd_addr_o,
  output logic                    rd_req_o,
  input  logic [2*DATA_WIDTH-1:0] rd_data_i,
  output logic                    late_o
);

  localparam int LAT = clamp_latency(RD_LATENCY);

  logic active;
  logic start;

  emif_strobe_sync #(
    .SYNC_STEPS(SYNC_STEPS)
  ) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .cs_n_i  (emif_cs_n_i),
    .oe_n_i  (emif_oe_n_i),
    .active_o(active),
    .start_o (start)
  );

  emif_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt;
  logic [1:0]            cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  oe_nxt;
  logic                  req_nxt;
  logic [ADDR_WIDTH-2:0] rd_addr_nxt;
  logic                  late_nxt;
  logic [DATA_WIDTH-1:0] shadow, shadow_nxt;
  logic [ADDR_WIDTH-2:0] shadow_addr, shadow_addr_nxt;
  logic                  shadow_valid, shadow_valid_nxt;
  logic                  shadow_hit;

  assign shadow_hit = emif_addr_i[0] && shadow_valid &&
                      (shadow_addr == emif_addr_i[ADDR_WIDTH-1:1]);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= ST_IDLE;
      addr_r         <= '0;
      cnt            <= '0;
      emif_data_o    <= '0;
      emif_data_oe_o <= 1'b0;
      rd_req_o       <= 1'b0;
      rd_addr_o      <= '0;
      late_o         <= 1'b0;
      shadow         <= '0;
      shadow_addr    <= '0;
      shadow_valid   <= 1'b0;
    end else begin
      state          <= state_nxt;
      addr_r         <= addr_nxt;
      cnt            <= cnt_nxt;
      emif_data_o    <= data_nxt;
      emif_data_oe_o <= oe_nxt;
      rd_req_o       <= req_nxt;
      rd_addr_o      <= rd_addr_nxt;
      late_o         <= late_nxt;
      shadow         <= shadow_nxt;
      shadow_addr    <= shadow_addr_nxt;
      shadow_valid   <= shadow_valid_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    addr_nxt         = addr_r;
    cnt_nxt          = cnt;
    data_nxt         = emif_data_o;
    oe_nxt           = emif_data_oe_o;
    req_nxt          = 1'b0;
    rd_addr_nxt      = rd_addr_o;
    late_nxt         = 1'b0;
    shadow_nxt       = shadow;
    shadow_addr_nxt  = shadow_addr;
    shadow_valid_nxt = shadow_valid;

    case (state)
      ST_IDLE: begin
        oe_nxt = 1'b0;
        if (start) begin
          addr_nxt = emif_addr_i;
          // A matching shadow serves exactly one high-half read, then retires.
          if (shadow_hit) begin
            data_nxt         = shadow;
            oe_nxt           = 1'b1;
            shadow_valid_nxt = 1'b0;
            state_nxt        = ST_DRIVE;
          end else begin
            req_nxt     = 1'b1;
            rd_addr_nxt = emif_addr_i[ADDR_WIDTH-1:1];
            cnt_nxt     = 2'(LAT);
            state_nxt   = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        if (!active) begin
          late_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == 2'd0) begin
          oe_nxt    = 1'b1;
          state_nxt = ST_DRIVE;
          if (!addr_r[0]) begin
            data_nxt         = rd_data_i[DATA_WIDTH-1:0];
            shadow_nxt       = rd_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
            shadow_addr_nxt  = addr_r[ADDR_WIDTH-1:1];
            shadow_valid_nxt = 1'b1;
          end else begin
            data_nxt = rd_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
          end
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end

      ST_DRIVE: begin
        if (!active) begin
          oe_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_emif_tx_responder.sv
// Randomised self-checking bench for emif_tx_responder with a register-file
// model and a transaction-level reference model of the shadow behaviour.
module tb_emif_tx_responder;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int SYNC = 2;
  localparam int LAT  = 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          emif_cs_n_i;
  logic          emif_oe_n_i;
  logic [AW-1:0] emif_addr_i;
  logic [DW-1:0] emif_data_o;
  logic          emif_data_oe_o;
  logic [AW-2:0] rd_addr_o;
  logic          rd_req_o;
  logic [2*DW-1:0] rd_data_i;
  logic          late_o;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit            m_sv;
  logic [AW-2:0] m_saddr;
  logic [DW-1:0] m_shadow;

  logic [31:0]   mem [0:127];
  logic          pv [LAT];
  logic [AW-2:0] pa [LAT];

  emif_tx_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SYNC_STEPS(SYNC),
    .RD_LATENCY(LAT)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .emif_cs_n_i   (emif_cs_n_i),
    .emif_oe_n_i   (emif_oe_n_i),
    .emif_addr_i   (emif_addr_i),
    .emif_data_o   (emif_data_o),
    .emif_data_oe_o(emif_data_oe_o),
    .rd_addr_o     (rd_addr_o),
    .rd_req_o      (rd_req_o),
    .rd_data_i     (rd_data_i),
    .late_o        (late_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file: data is valid exactly LAT cycles after the request pulse.
  always @(posedge clk_i) begin
    pv[0] <= rd_req_o;
    pa[0] <= rd_addr_o;
    for (int j = 1; j < LAT; j++) begin
      pv[j] <= pv[j-1];
      pa[j] <= pa[j-1];
    end
  end
  assign rd_data_i = (pv[LAT-1] === 1'b1) ? mem[pa[LAT-1]] : 32'hDEAD_5A5A;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One complete read strobe of w cycles, checked against the model.
  task automatic do_read(input logic [AW-1:0] a, input int w, input string tag);
    int            req_cnt, first_oe, oe_cnt, late_cnt, drive_e, drop_e;
    logic [AW-2:0] req_a;
    logic [DW-1:0] dat, exp_dat;
    logic [31:0]   word;
    bit            hit, late;
    req_cnt = 0; first_oe = 0; oe_cnt = 0; late_cnt = 0;
    req_a = '0; dat = '0;
    word    = mem[a[AW-1:1]];
    hit     = a[0] && m_sv && (m_saddr == a[AW-1:1]);
    drive_e = hit ? SYNC + 1 : SYNC + LAT + 2;
    drop_e  = w + SYNC + 1;
    late    = !hit && (drop_e <= drive_e);
    exp_dat = hit ? m_shadow : (a[0] ? word[31:16] : word[15:0]);

    @(negedge clk_i);
    emif_addr_i = a; emif_cs_n_i = 1'b0; emif_oe_n_i = 1'b0;
    for (int k = 1; k <= w + SYNC + 4; k++) begin
      @(posedge clk_i); #1;
      if (rd_req_o) begin req_cnt++; req_a = rd_addr_o; end
      if (emif_data_oe_o) begin
        if (first_oe == 0) begin first_oe = k; dat = emif_data_o; end
        oe_cnt++;
      end
      if (late_o) late_cnt++;
      if (k == w) begin emif_cs_n_i = 1'b1; emif_oe_n_i = 1'b1; end
    end

    n_cmp++;
    if (req_cnt !== (hit ? 0 : 1)) begin
      n_err++; $display("FAIL %s req_cnt: got %0d want %0d", tag, req_cnt, hit ? 0 : 1);
    end
    if (!hit) begin
      n_cmp++;
      if (req_a !== a[AW-1:1]) begin
        n_err++; $display("FAIL %s rd_addr: got %0h want %0h", tag, req_a, a[AW-1:1]);
      end
    end
    n_cmp++;
    if (late_cnt !== (late ? 1 : 0)) begin
      n_err++; $display("FAIL %s late_cnt: got %0d want %0d", tag, late_cnt, late ? 1 : 0);
    end
    n_cmp++;
    if (first_oe !== (late ? 0 : drive_e)) begin
      n_err++; $display("FAIL %s oe_first_cycle: got %0d want %0d", tag, first_oe, late ? 0 : drive_e);
    end
    n_cmp++;
    if (oe_cnt !== (late ? 0 : drop_e - drive_e)) begin
      n_err++; $display("FAIL %s oe_cycles: got %0d want %0d", tag, oe_cnt, late ? 0 : drop_e - drive_e);
    end
    if (!late) begin
      n_cmp++;
      if (dat !== exp_dat) begin
        n_err++; $display("FAIL %s data: got %0h want %0h", tag, dat, exp_dat);
      end
    end

    if (hit) m_sv = 1'b0;
    else if (!late && !a[0]) begin
      m_sv = 1'b1; m_saddr = a[AW-1:1]; m_shadow = word[31:16];
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; emif_cs_n_i = 1'b1; emif_oe_n_i = 1'b1; emif_addr_i = '0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("rst_data", 32'(emif_data_o), 32'h0);
    chk("rst_oe", 32'(emif_data_oe_o), 32'h0);
    chk("rst_req", 32'(rd_req_o), 32'h0);
    chk("rst_late", 32'(late_o), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'h0);
    reset_i = 1'b0;
    m_sv = 1'b0; m_saddr = '0; m_shadow = '0;
    repeat (3) @(posedge clk_i);
  endtask

  task automatic test_low_high_coherent();
    mem[8'h08] = 32'hBEEF_1234;
    do_read(8'h10, 8, "low10");
    mem[8'h08] = 32'h0000_0000;
    do_read(8'h11, 8, "hi11_hit");
    do_read(8'h11, 8, "hi11_refetch");
  endtask

  task automatic test_shadow_miss();
    mem[8'h10] = 32'hCAFE_0001;
    do_read(8'h21, 8, "hi21_miss");
  endtask

  task automatic test_late();
    mem[8'h30] = 32'h7777_1111;
    mem[8'h40] = 32'h9999_2222;
    do_read(8'h60, 8, "late_setup");
    do_read(8'h80, LAT + 1, "late_short");
    do_read(8'h61, 8, "late_shadow_kept");
  endtask

  task automatic test_reset_mid();
    int req_cnt, oe_seen;
    req_cnt = 0; oe_seen = 0;
    mem[8'h08] = 32'h1357_2468;
    @(negedge clk_i);
    emif_addr_i = 8'h10; emif_cs_n_i = 1'b0; emif_oe_n_i = 1'b0;
    repeat (SYNC + LAT + 3) @(posedge clk_i);
    #1;
    chk("mid_oe_before_rst", 32'(emif_data_oe_o), 32'h1);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk("mid_oe_after_rst", 32'(emif_data_oe_o), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i); #1;
      if (rd_req_o) req_cnt++;
      if (emif_data_oe_o) oe_seen++;
    end
    chk("mid_no_req", 32'(req_cnt), 32'h0);
    chk("mid_no_oe", 32'(oe_seen), 32'h0);
    emif_cs_n_i = 1'b1; emif_oe_n_i = 1'b1;
    repeat (4) @(posedge clk_i);
    m_sv = 1'b0;
    do_read(8'h11, 8, "post_rst_hi11");
  endtask

  task automatic test_write_cycle();
    int req_cnt, oe_seen;
    req_cnt = 0; oe_seen = 0;
    @(negedge clk_i);
    emif_addr_i = 8'h10; emif_cs_n_i = 1'b0; emif_oe_n_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      if (rd_req_o) req_cnt++;
      if (emif_data_oe_o) oe_seen++;
    end
    emif_cs_n_i = 1'b1;
    repeat (4) @(posedge clk_i);
    chk("wr_no_req", 32'(req_cnt), 32'h0);
    chk("wr_no_oe", 32'(oe_seen), 32'h0);
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [7];
    logic [AW-1:0] a;
    pool[0] = 8'h10; pool[1] = 8'h11; pool[2] = 8'h20; pool[3] = 8'h21;
    pool[4] = 8'h40; pool[5] = 8'h41; pool[6] = 8'h00;
    for (int i = 0; i < 40; i++) begin
      a = pool[$urandom_range(0, 6)];
      if (a == 8'h00) a = 8'($urandom);
      if ($urandom_range(0, 2) == 0) mem[a[AW-1:1]] = $urandom;
      do_read(a, $urandom_range(1, 8), "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    test_reset();
    test_low_high_coherent();
    test_shadow_miss();
    test_late();
    test_reset_mid();
    test_write_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
